node_port_tx: RTL

- Transmit side of the TIS-100 node-to-node port interface. It executes "MOV <src>, <port>" by taking a word from the execution unit (normally ACC from the register file) and offering it on one of four neighbour ports.
- It holds the node stalled (busy) until a neighbour takes the word, which gives TIS-100 blocking-write semantics.
- It supports the UP/RIGHT/DOWN/LEFT, ANY, LAST and NIL destinations, and tracks the LAST port.

---
 rtl/node_port_tx_pkg.sv | 33 +++
 rtl/node_port_tx_any_arbiter.sv | 49 ++++
 rtl/node_port_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/node_port_tx_pkg.sv
// Shared types for the TIS-100 node transmit port: word type, destination codes and FSM states.
package node_port_tx_pkg;
  localparam int WORD_W     = 11;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_IDX_W = 2;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic [PORT_IDX_W-1:0]    port_idx_t;

  // Code 7 has no member here; the transmitter treats it like NIL.
  typedef enum logic [2:0] {
    UP    = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    ANY   = 3'd4,
    LAST  = 3'd5,
    NIL   = 3'd6
  } port_dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t idx);
    logic [NUM_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/node_port_tx_any_arbiter.sv
// Picks the ANY-write destination from the neighbours' ready vector.
// TX_ANY_RR_EN: round-robin from the port after the last ANY winner; otherwise UP>RIGHT>DOWN>LEFT.
module node_port_tx_any_arbiter
  import node_port_tx_pkg::*;
(
`ifdef TX_ANY_RR_EN
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 advance_i,
  input  port_idx_t            last_win_i,
`endif
  input  logic [NUM_PORTS-1:0] ready_i,
  output logic                 any_o,
  output port_idx_t            winner_o
);

  assign any_o = |ready_i;

`ifdef TX_ANY_RR_EN
  port_idx_t ptr_q;
  port_idx_t cand;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= last_win_i + port_idx_t'(1);
    end
  end

  // Walk downward so the ready port closest to ptr_q is the last assignment.
  always_comb begin
    winner_o = '0;
    cand     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = ptr_q + port_idx_t'(k);
      if (ready_i[cand]) winner_o = cand;
    end
  end
`else
  always_comb begin
    winner_o = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (ready_i[k]) winner_o = port_idx_t'(k);
    end
  end
`endif

endmodule

// File: rtl/node_port_tx.sv
// TIS-100 node transmit port: blocking MOV to UP/RIGHT/DOWN/LEFT/ANY/LAST/NIL with LAST tracking.
// Optional macro TX_ANY_RR_EN selects round-robin ANY arbitration.
module node_port_tx
  import node_port_tx_pkg::*;
(
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              send,
  input  logic [2:0]                        dir,
  input  word_t                             data_in,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_PORTS-1:0][WORD_W-1:0]  tx_data,
  output logic [NUM_PORTS-1:0]              tx_valid,
  input  logic [NUM_PORTS-1:0]              tx_ready,
  output port_idx_t                         last_dir,
  output logic                              last_valid,
  output tx_state_t                         dbg_state_o
);

  // Handshake: a word moves on port i at a clock edge where tx_valid[i] & tx_ready[i].
  // tx_valid[i] is held until that edge; a raised tx_ready[i] is likewise held by the receiver.

  tx_state_t            state_q;
  word_t                data_q;
  port_idx_t            target_q;
  logic                 any_q;
  logic [NUM_PORTS-1:0] tx_valid_q;
  logic                 done_q;
  port_idx_t            last_dir_q;
  logic                 last_valid_q;

  logic      xfer;
  logic      arb_any;
  port_idx_t arb_winner;

  assign xfer = |(tx_valid_q & tx_ready);

  node_port_tx_any_arbiter u_arb (
`ifdef TX_ANY_RR_EN
    .clk        (clk),
    .nrst       (nrst),
    .advance_i  ((state_q == SEND) && xfer && any_q),
    .last_win_i (target_q),
`endif
    .ready_i    (tx_ready),
    .any_o      (arb_any),
    .winner_o   (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      target_q     <= '0;
      any_q        <= 1'b0;
      tx_valid_q   <= '0;
      done_q       <= 1'b0;
      last_dir_q   <= '0;
      last_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send) begin
            data_q <= data_in;
            any_q  <= 1'b0;
            case (port_dir_t'(dir))
              UP, RIGHT, DOWN, LEFT: begin
                target_q   <= dir[1:0];
                tx_valid_q <= port_onehot(dir[1:0]);
                state_q    <= SEND;
              end
              ANY: begin
                any_q   <= 1'b1;
                state_q <= ARB;
              end
              LAST: begin
                if (last_valid_q) begin
                  target_q   <= last_dir_q;
                  tx_valid_q <= port_onehot(last_dir_q);
                  state_q    <= SEND;
                end else begin
                  done_q <= 1'b1;
                end
              end
              // NIL and the reserved code discard the word without stalling.
              default: done_q <= 1'b1;
            endcase
          end
        end
        ARB: begin
          if (arb_any) begin
            target_q   <= arb_winner;
            tx_valid_q <= port_onehot(arb_winner);
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            tx_valid_q <= '0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
            if (any_q) begin
              last_dir_q   <= target_q;
              last_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_valid_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = {NUM_PORTS{data_q}};
  assign last_dir    = last_dir_q;
  assign last_valid  = last_valid_q;
  assign dbg_state_o = state_q;

endmodule
